// File: rtl/axi_pkg.sv
// Shared AXI4 encodings used by the read master and the slave RAM.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/axi_read_master_if.sv
// AXI4 read address and read data channels between one master and one slave.
interface axi_read_master_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
);

  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_out_reg.sv
// One-entry valid/ready holding register. A consume and a reload in the same
// cycle are allowed, so a streaming producer sees one beat per cycle.
module axi_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             accept_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;

  assign accept_o = !valid_q || ready_i;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign last_o   = last_q;

  // Load wins over consume; a consume without reload empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read master: one client command becomes one INCR burst; returned beats
// are forwarded through a one-entry output register with back-pressure.
//
// state | meaning
// IDLE  | ready for a client command (last beat may still sit in out reg)
// ADDR  | arvalid high with latched fields until arready
// DATA  | collecting R beats until the counted final beat is taken
module axi_read_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  axi_read_master_if.master        axi,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     err
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(STROBE_WIDTH));

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               len_q, len_d;
  logic [2:0]               size_q, size_d;
  logic [8:0]               beats_left_q, beats_left_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;
  logic                     arvalid_c, rready_c, out_load, out_accept, final_beat;

  assign final_beat  = (beats_left_q == 9'd1);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = arvalid_c;
  assign axi.rready  = rready_c;
  assign done        = done_q;
  assign err         = err_q;

  // State and burst bookkeeping registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      beats_left_q <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      beats_left_q <= beats_left_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  // Next-state, handshakes and error/done decisions.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    beats_left_d = beats_left_q;
    err_d        = err_q;
    done_d       = 1'b0;
    cmd_ready    = 1'b0;
    arvalid_c    = 1'b0;
    rready_c     = 1'b0;
    out_load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d       = cmd_addr;
          len_d        = cmd_len;
          size_d       = cmd_size;
          beats_left_d = {1'b0, cmd_len} + 9'd1;
          err_d        = 1'b0;
          if (cmd_size > SIZE_MAX) begin
            // Illegal beat size: report and finish without touching the bus.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        arvalid_c = 1'b1;
        if (axi.arready) state_d = DATA;
      end
      DATA: begin
        rready_c = out_accept;
        if (axi.rvalid && out_accept) begin
          out_load     = 1'b1;
          beats_left_d = beats_left_q - 9'd1;
          if (axi.rresp != RESP_OKAY) err_d = 1'b1;
          if (axi.rlast != final_beat) err_d = 1'b1;
          if (final_beat) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  axi_out_reg #(.WIDTH(DATA_WIDTH)) u_out_reg (
    .clk      (aclk),
    .rst      (areset),
    .load_i   (out_load),
    .data_i   (axi.rdata),
    .last_i   (final_beat),
    .ready_i  (out_ready),
    .accept_o (out_accept),
    .valid_o  (out_valid),
    .data_o   (out_data),
    .last_o   (out_last)
  );

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
- AXI4 read-channel master sitting directly upstream of axi_slave_ram (AR/R channels).
- Accepts one burst command at a time from a local client and issues a single INCR burst on AR.
- Collects the R beats and forwards them to the client through a one-entry registered output stream with back-pressure.
- Pulses done when the final beat has been captured; error status is sticky for that burst.

Parameters:
DATA_WIDTH, 32, R data bus width in bits (multiple of 8)
STROBE_WIDTH, DATA_WIDTH/8, bytes per data beat
ADDRESS_WIDTH, 8, byte address width
SIZE_MAX, log2(STROBE_WIDTH), largest legal cmd_size

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
cmd_valid  in  1  client command valid
cmd_ready  out  1  master can accept a command
cmd_addr  in  ADDRESS_WIDTH  burst start byte address
cmd_len  in  8  beats minus one (AXI encoding)
cmd_size  in  3  log2 bytes per beat
araddr  out  ADDRESS_WIDTH  AR address
arlen  out  8  AR length
arsize  out  3  AR size
arburst  out  2  fixed 2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  DATA_WIDTH  R data
rresp  in  2  R response
rlast  in  1  R last
rvalid  in  1  R valid
rready  out  1  R ready
out_data  out  DATA_WIDTH  captured beat
out_last  out  1  beat is last of burst
out_valid  out  1  out register holds a beat
out_ready  in  1  client consumes beat
done  out  1  one-cycle pulse, burst finished
err  out  1  sticky error for the current or last burst; cleared on next cmd accept

Behaviour:
- Reset: state IDLE; arvalid=0, rready=0, out_valid=0, out_last=0, out_data=0, done=0, err=0, araddr/arlen/arsize=0.
- Reset mid-operation: everything returns to reset values next edge. arvalid dropping without handshake is accepted; the system resets the slave together with the master.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/len/size, load beats_left=cmd_len+1 (9-bit), clear err.
    - If cmd_size>SIZE_MAX: set err, pulse done next cycle, stay IDLE, no AR issued.
    - Otherwise go ADDR.
  - ADDR: arvalid=1 with latched fields, held stable until arready. On arvalid&&arready go DATA (one cycle min).
  - DATA: rready = !out_valid || out_ready.
    - On rvalid&&rready: load out_data=rdata, out_valid=1, out_last=(beats_left==1); decrement beats_left.
    - If rresp!=0: set err.
    - rlast mismatch (rlast!=(beats_left==1)): set err.
    - When beats_left==1 beat is taken: pulse done next cycle, go IDLE.
- Output register: out_valid clears on out_ready unless reloaded the same cycle. Simultaneous consume and load is legal, giving full throughput of one beat per cycle.
- cmd_ready=1 in IDLE even while the final beat is still held in the out register. A new burst's first beat waits behind it via rready.
- Latency: cmd accept -> arvalid next cycle; R handshake -> out_valid next cycle.
- No address arithmetic is done here; the slave computes beat addresses. Data lanes are passed through unmodified (unused lanes arrive zeroed from the slave).
- arlen=255 gives 256 beats; the 9-bit counter handles it.

Decomposition:
- Shared package axi_pkg:
  - BURST_FIXED/INCR/WRAP constants
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - state encoding localparams IDLE/ADDR/DATA
- Shared by this block and axi_slave_ram.
- Optional sub-module axi_out_reg: the one-entry valid/ready data register, reusable for a write-response path.

Test Plan:
- axi_slave_ram with ram[i]=i; cmd addr=4 len=3 size=2 -> arlen=3; out beats 0x07060504, 0x0B0A0908, 0x0F0E0D0C, 0x13121110; out_last on 4th; one done pulse; err=0.
- Unaligned cmd addr=5 len=0 size=2 -> single beat 0x07060500, out_last=1, done.
- out_ready held low 5 cycles mid-burst -> rready low while out_valid; no beat lost or duplicated; order preserved.
- Mock slave returns rresp=2 on beat 2 of 4 -> all 4 beats delivered, err=1 after beat 2, cleared on next cmd accept.
- cmd_size=3 with DATA_WIDTH=32 -> no arvalid ever; err=1; done one cycle after accept.
- areset asserted during DATA after 2 of 4 beats -> next edge all outputs at reset values; a fresh cmd then completes correctly.
